exh_vector_sweeper: RTL and testbench

//  Self-checking exhaustive stimulus engine for small combinational blocks.

---
 rtl/exh_vector_sweeper_pkg.sv | 22 ++
 rtl/exh_vector_sweeper_bin2gray.sv | 19 +
 rtl/exh_vector_sweeper.sv | 153 +++++++++++++++
 tb/tb_exh_vector_sweeper.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exh_vector_sweeper_pkg.sv
// ============================================================================
// Module  : exh_vector_sweeper_pkg
// Purpose : Shared state encodings and mode-bit indices for the vector sweeper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package exh_vector_sweeper_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_HOLD  = 2'd2,
    S_DONE  = 2'd3
  } sweep_state_t;

  localparam int MODE_GRAY = 0;
  localparam int MODE_STEP = 1;

endpackage

`default_nettype wire

// File: rtl/exh_vector_sweeper_bin2gray.sv
// ============================================================================
// Module  : exh_vector_sweeper_bin2gray
// Purpose : Combinational binary-to-Gray encoder for the sweep index.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module exh_vector_sweeper_bin2gray #(
  parameter int W = 3
) (
  input  logic [W-1:0] i_bin,
  output logic [W-1:0] o_gray
);

  assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

`default_nettype wire

// File: rtl/exh_vector_sweeper.sv
// ============================================================================
// Module  : exh_vector_sweeper
// Purpose : Exhaustive stimulus engine; drives every input vector, compares
//           DUT against reference at the end of each dwell, records failures.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module exh_vector_sweeper
  import exh_vector_sweeper_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int N_OUT = 2,
  parameter int DWELL = 79
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic             step,
  input  logic [N_OUT-1:0] dut_y,
  input  logic [N_OUT-1:0] ref_y,
  output logic [N_IN-1:0]  vec_out,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [N_IN:0]    err_count,
  output logic             first_err_vld,
  output logic [N_IN-1:0]  first_err_vec
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int EW = N_IN + 1;
  localparam logic [CW-1:0]   c_cnt_last = CW'(DWELL - 1);
  localparam logic [N_IN-1:0] c_idx_last = '1;

  sweep_state_t    r_state;
  sweep_state_t    w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [N_IN-1:0] r_idx;
  logic [N_IN-1:0] r_vec;
  logic [1:0]      r_mode;
  logic            r_mismatch;
  logic [EW-1:0]   r_err_cnt;
  logic            r_fvld;
  logic [N_IN-1:0] r_fvec;

  logic            w_busy;
  logic            w_start;
  logic            w_abort;
  logic            w_last;
  logic            w_fail;
  logic            w_adv;
  logic [N_IN-1:0] w_idx_nxt;
  logic [N_IN-1:0] w_gray_nxt;

  assign w_busy    = (r_state == S_DRIVE) || (r_state == S_HOLD);
  assign w_start   = start && !abort && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_abort   = abort && w_busy;
  assign w_last    = (r_cnt == c_cnt_last);
  assign w_fail    = (r_state == S_DRIVE) && w_last && !abort && (|(dut_y ^ ref_y));
  assign w_idx_nxt = r_idx + N_IN'(1);

  // Advance to the next vector: end of dwell in free-run, or a step while held.
  assign w_adv = !abort &&
                 (((r_state == S_DRIVE) && w_last && (r_idx != c_idx_last) && !r_mode[MODE_STEP]) ||
                  ((r_state == S_HOLD) && step));

  exh_vector_sweeper_bin2gray #(.W(N_IN)) u_bin2gray (
    .i_bin  (w_idx_nxt),
    .o_gray (w_gray_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_DRIVE;
      S_DRIVE: begin
        if (abort)                         w_state_nxt = S_IDLE;
        else if (w_last) begin
          if (r_idx == c_idx_last)         w_state_nxt = S_DONE;
          else if (r_mode[MODE_STEP])      w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (abort)     w_state_nxt = S_IDLE;
        else if (step) w_state_nxt = S_DRIVE;
      end
      S_DONE:  if (w_start) w_state_nxt = S_DRIVE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_vec      <= '0;
      r_mode     <= '0;
      r_mismatch <= 1'b0;
      r_err_cnt  <= '0;
      r_fvld     <= 1'b0;
      r_fvec     <= '0;
    end else begin
      r_mismatch <= w_fail;
      if (w_start) begin
        r_mode    <= mode;
        r_idx     <= '0;
        r_cnt     <= '0;
        r_vec     <= '0;
        r_err_cnt <= '0;
        r_fvld    <= 1'b0;
        r_fvec    <= '0;
      end else if (w_abort) begin
        r_idx <= '0;
        r_cnt <= '0;
        r_vec <= '0;
      end else begin
        if (w_fail) begin
          r_err_cnt <= r_err_cnt + EW'(1);
          if (!r_fvld) begin
            r_fvld <= 1'b1;
            r_fvec <= r_vec;
          end
        end
        if (w_adv) begin
          r_idx <= w_idx_nxt;
          r_cnt <= '0;
          r_vec <= r_mode[MODE_GRAY] ? w_gray_nxt : w_idx_nxt;
        end else if ((r_state == S_DRIVE) && !w_last) begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign vec_out       = r_vec;
  assign busy          = w_busy;
  assign done          = (r_state == S_DONE);
  assign mismatch      = r_mismatch;
  assign err_count     = r_err_cnt;
  assign first_err_vld = r_fvld;
  assign first_err_vec = r_fvec;

endmodule

`default_nettype wire

// File: tb/tb_exh_vector_sweeper.sv
// ============================================================================
// Module  : tb_exh_vector_sweeper
// Purpose : Self-checking bench for exh_vector_sweeper (N_IN=3, N_OUT=2, DWELL=4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exh_vector_sweeper;

  localparam int N_IN  = 3;
  localparam int N_OUT = 2;
  localparam int DWELL = 4;
  localparam int NV    = 8;
  localparam int P_IDLE = 0, P_RUN = 1, P_WAIT = 2, P_DONE = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             step = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [N_OUT-1:0] dut_y, ref_y;
  logic [N_IN-1:0]  vec_out;
  logic             busy, done, mismatch;
  logic [N_IN:0]    err_count;
  logic             first_err_vld;
  logic [N_IN-1:0]  first_err_vec;

  logic             inj_en = 1'b0;
  logic [N_IN-1:0]  inj_vec = '0;
  logic [N_OUT-1:0] inj_mask = '0;

  int total = 0;
  int bad = 0;
  int mis_seen = 0;

  assign ref_y = vec_out[1:0] ^ {2{vec_out[2]}};
  assign dut_y = ref_y ^ ((inj_en && vec_out == inj_vec) ? inj_mask : '0);

  exh_vector_sweeper #(.N_IN(N_IN), .N_OUT(N_OUT), .DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .step(step), .dut_y(dut_y), .ref_y(ref_y), .vec_out(vec_out),
    .busy(busy), .done(done), .mismatch(mismatch), .err_count(err_count),
    .first_err_vld(first_err_vld), .first_err_vec(first_err_vec)
  );

  always #5 clk = ~clk;

  function automatic int seq_vec(input int k, input bit g);
    return g ? (k ^ (k >> 1)) : k;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // Sweep model: phase, vector ordinal and clocks spent on the current vector.
  int m_ph = P_IDLE, m_k = 0, m_t = 0, m_errs = 0, m_fvec = 0;
  bit m_gray = 0, m_stepm = 0, m_fvld = 0, m_mis = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= P_IDLE; m_k <= 0; m_t <= 0; m_errs <= 0; m_fvec <= 0;
      m_gray <= 0; m_stepm <= 0; m_fvld <= 0; m_mis <= 0;
    end else begin
      m_mis <= 0;
      if (m_ph == P_IDLE || m_ph == P_DONE) begin
        if (start && !abort) begin
          m_ph <= P_RUN; m_k <= 0; m_t <= 0; m_errs <= 0; m_fvld <= 0; m_fvec <= 0;
          m_gray <= mode[0]; m_stepm <= mode[1];
        end
      end else if (abort) begin
        m_ph <= P_IDLE; m_k <= 0; m_t <= 0;
      end else if (m_ph == P_WAIT) begin
        if (step) begin
          m_ph <= P_RUN; m_k <= m_k + 1; m_t <= 0;
        end
      end else if (m_t < DWELL - 1) begin
        m_t <= m_t + 1;
      end else begin
        if (inj_en && inj_mask != 0 && seq_vec(m_k, m_gray) == int'(inj_vec)) begin
          m_errs <= m_errs + 1;
          m_mis  <= 1;
          if (!m_fvld) begin
            m_fvld <= 1;
            m_fvec <= seq_vec(m_k, m_gray);
          end
        end
        if (m_k == NV - 1)  m_ph <= P_DONE;
        else if (m_stepm)   m_ph <= P_WAIT;
        else begin
          m_k <= m_k + 1; m_t <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("vec_out", int'(vec_out), (m_ph == P_IDLE) ? 0 : seq_vec(m_k, m_gray));
    chk("busy", int'(busy), int'(m_ph == P_RUN || m_ph == P_WAIT));
    chk("done", int'(done), int'(m_ph == P_DONE));
    chk("mismatch", int'(mismatch), int'(m_mis));
    chk("err_count", int'(err_count), m_errs);
    chk("first_err_vld", int'(first_err_vld), int'(m_fvld));
    chk("first_err_vec", int'(first_err_vec), m_fvec);
    if (mismatch === 1'b1) mis_seen++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [1:0] m);
    mode = m; start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int lim, output int n);
    n = 0;
    while (!done && n < lim) begin tick(1); n++; end
    if (!done) timeout(nm);
  endtask

  task automatic wait_vec(input string nm, input int v, input int lim);
    int c = 0;
    while (int'(vec_out) != v && c < lim) begin tick(1); c++; end
    if (int'(vec_out) != v) timeout(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int q[$];
    int gray_exp[8];
    gray_exp = '{0, 1, 3, 2, 6, 7, 5, 4};

    tick(2);
    chk("rst_vec", int'(vec_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err_count), 0);
    rst_n = 1'b1;
    tick(1);

    // Binary free-run, no failures.
    mis_seen = 0;
    do_start(2'b00);
    chk("t1_busy_rise", int'(busy), 1);
    wait_done("t1_done", 100, n);
    chk("t1_latency", n, 32);
    chk("t1_err", int'(err_count), 0);
    chk("t1_mis_pulses", mis_seen, 0);
    chk("t1_last_vec", int'(vec_out), 7);

    // Single failure on vector 5.
    inj_en = 1'b1; inj_vec = 3'd5; inj_mask = 2'b01;
    mis_seen = 0;
    do_start(2'b00);
    wait_done("t2_done", 100, n);
    chk("t2_err", int'(err_count), 1);
    chk("t2_fvec", int'(first_err_vec), 5);
    chk("t2_fvld", int'(first_err_vld), 1);
    chk("t2_mis_pulses", mis_seen, 1);
    start = 1'b1; abort = 1'b1; tick(1); start = 1'b0; abort = 1'b0;
    chk("t2_start_abort_done", int'(done), 1);
    chk("t2_start_abort_err", int'(err_count), 1);
    inj_en = 1'b0;

    // Gray order.
    do_start(2'b01);
    q.push_back(int'(vec_out));
    n = 0;
    while (!done && n < 100) begin
      tick(1); n++;
      if (int'(vec_out) != q[$]) q.push_back(int'(vec_out));
    end
    if (!done) timeout("t3_done");
    chk("t3_len", q.size(), 8);
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      chk("t3_seq", q[i], gray_exp[i]);
      if (i > 0) chk("t3_onebit", $countones(q[i] ^ q[i-1]), 1);
    end

    // Single-step mode; stray steps in DRIVE and on the HOLD-entry clock.
    do_start(2'b10);
    for (int i = 0; i < 7; i++) begin
      tick(1);
      step = (i == 1);
      tick(2);
      step = (i == 0);
      tick(1);
      step = 1'b0;
      chk("t4_hold_vec", int'(vec_out), seq_vec(i, 1'b0));
      tick(2);
      chk("t4_held_vec", int'(vec_out), i);
      step = 1'b1; tick(1); step = 1'b0;
      chk("t4_step_vec", int'(vec_out), i + 1);
    end
    tick(4);
    chk("t4_done", int'(done), 1);

    // Abort on vector 3 after a failure on vector 1.
    inj_en = 1'b1; inj_vec = 3'd1; inj_mask = 2'b10;
    do_start(2'b00);
    wait_vec("t5_reach3", 3, 40);
    tick(1);
    abort = 1'b1; tick(1); abort = 1'b0;
    chk("t5_busy", int'(busy), 0);
    chk("t5_done", int'(done), 0);
    chk("t5_vec", int'(vec_out), 0);
    chk("t5_err", int'(err_count), 1);
    chk("t5_fvec", int'(first_err_vec), 1);
    abort = 1'b1; tick(1); abort = 1'b0;
    chk("t5_idle_abort_err", int'(err_count), 1);
    do_start(2'b00);
    chk("t5_restart_err", int'(err_count), 0);
    chk("t5_restart_fvld", int'(first_err_vld), 0);

    // Asynchronous reset mid-vector 6.
    wait_vec("t6_reach6", 6, 40);
    tick(1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_vec", int'(vec_out), 0);
    chk("t6_async_busy", int'(busy), 0);
    chk("t6_async_err", int'(err_count), 0);
    chk("t6_async_fvld", int'(first_err_vld), 0);
    tick(2);
    rst_n = 1'b1;
    inj_en = 1'b0;
    tick(1);
    do_start(2'b00);
    chk("t6_restart_vec", int'(vec_out), 0);
    chk("t6_restart_busy", int'(busy), 1);
    wait_done("t6_done", 100, n);
    chk("t6_latency", n, 32);

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
